if_id_stage: RTL and testbench

- Fetch/decode boundary register of the 5-stage pipeline.
- Directly downstream of the program counter block. Each cycle it captures the instruction word read from instruction memory at the current PC, together with that PC.
- Pre-decodes jump/branch class and returns jon_d/addr_d to the PC block. Feeds pc_d back as the PC block's pc_in.
- Squashes wrong-path instructions in jump/branch shadows and latches halt.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/jon_predecode.sv | 29 ++
 rtl/if_id_stage.sv | 116 +++++++++++
 tb/tb_if_id_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the 5-stage pipeline: opcode numbers, the
// jump/branch class encoding (jon) handed back to the PC block, and the
// instruction word injected into squashed slots.
// No ports; imported with "import pipeline_pkg::*;".
package pipeline_pkg;

  localparam logic [5:0] OP_BEQ  = 6'd32;
  localparam logic [5:0] OP_BNE  = 6'd33;
  localparam logic [5:0] OP_BLT  = 6'd34;
  localparam logic [5:0] OP_BLE  = 6'd35;
  localparam logic [5:0] OP_J    = 6'd40;
  localparam logic [5:0] OP_JR   = 6'd42;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Redirect class understood by the PC block.
  typedef enum logic [1:0] {
    JON_NONE   = 2'b00,
    JON_JUMP   = 2'b01,
    JON_BRANCH = 2'b10
  } jon_t;

endpackage

// File: rtl/jon_predecode.sv
// jon_predecode
// Purely combinational opcode classifier: maps a 6-bit opcode to the
// redirect class the PC block expects. Also used by the hazard unit.
// Ports:
//   op   in  6  opcode field (instruction bits 31:26)
//   jon  out 2  JON_JUMP for the direct jump, JON_BRANCH for conditional
//               branches and jr, JON_NONE otherwise
module jon_predecode
  import pipeline_pkg::*;
#(
  parameter logic [5:0] J_OP = OP_J
) (
  input  logic [5:0] op,
  output logic [1:0] jon
);

  always_comb begin
    jon = JON_NONE;
    if (op == J_OP) begin
      jon = JON_JUMP;
    end else begin
      unique case (op)
        OP_BEQ, OP_BNE, OP_BLT, OP_BLE, OP_JR: jon = JON_BRANCH;
        default:                               jon = JON_NONE;
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage
// Fetch/decode boundary register. Captures the instruction read at pc
// together with pc, pre-decodes its jump/branch class for the PC block,
// squashes wrong-path slots in jump (1 slot) and branch (2 slots) shadows,
// and latches a sticky halt.
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous active-high reset
//   pc         in   XLEN  current PC (word address)
//   imem_data  in   32    instruction word read at pc
//   stall      in   1     freeze the stage this cycle
//   instr_d    out  32    registered instruction (NOP_WORD when squashed)
//   pc_d       out  XLEN  registered PC of instr_d, fed back to the PC block
//   valid_d    out  1     instr_d is a real instruction
//   jon_d      out  2     redirect class of instr_d
//   addr_d     out  26    jump target field captured with instr_d
//   halted     out  1     sticky halt flag
// Optional build macro IF_ID_PERF_CNT_EN adds perf_jump, perf_branch and
// perf_bubble (32-bit event counters).
module if_id_stage
  import pipeline_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD,
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter logic [5:0]  J_OP     = 6'd40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     imem_data,
  input  logic            stall,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic            valid_d,
  output logic [1:0]      jon_d,
  output logic [25:0]     addr_d,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0]     perf_jump,
  output logic [31:0]     perf_branch,
  output logic [31:0]     perf_bubble,
`endif
  output logic            halted
);

  logic [1:0] jon_f;
  logic [1:0] squash_cnt;
  logic       capture;
  logic       squashing;

  jon_predecode #(.J_OP(J_OP)) u_predecode (
    .op  (imem_data[31:26]),
    .jon (jon_f)
  );

  assign capture   = !stall && !halted;
  assign squashing = (squash_cnt != 2'd0);

  // Main pipeline register. A squashed slot still advances pc_d so the
  // PC block's branch base stays correct; a jump/branch in a shadow slot
  // is discarded and cannot re-arm the squash count.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d    <= NOP_WORD;
      pc_d       <= '0;
      valid_d    <= 1'b0;
      jon_d      <= JON_NONE;
      addr_d     <= '0;
      halted     <= 1'b0;
      squash_cnt <= 2'd0;
    end else if (capture) begin
      pc_d <= pc;
      if (squashing) begin
        instr_d    <= NOP_WORD;
        valid_d    <= 1'b0;
        jon_d      <= JON_NONE;
        squash_cnt <= squash_cnt - 2'd1;
      end else begin
        instr_d <= imem_data;
        valid_d <= 1'b1;
        addr_d  <= imem_data[25:0];
        jon_d   <= jon_f;
        if (jon_f == JON_JUMP) begin
          squash_cnt <= 2'd1;
        end else if (jon_f == JON_BRANCH) begin
          squash_cnt <= 2'd2;
        end else begin
          squash_cnt <= 2'd0;
        end
        if (imem_data[31:26] == HALT_OP) begin
          halted <= 1'b1;
        end
      end
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Event counters advance only on edges where the stage actually captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jump   <= '0;
      perf_branch <= '0;
      perf_bubble <= '0;
    end else if (capture) begin
      if (squashing) begin
        perf_bubble <= perf_bubble + 32'd1;
      end else if (jon_f == JON_JUMP) begin
        perf_jump <= perf_jump + 32'd1;
      end else if (jon_f == JON_BRANCH) begin
        perf_branch <= perf_branch + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage
// Directed bench for if_id_stage: inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] imem_data;
  logic        stall;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [1:0]  jon_d;
  logic [25:0] addr_d;
  logic        halted;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_jump;
  logic [31:0] perf_branch;
  logic [31:0] perf_bubble;
`endif

  int total = 0;
  int bad   = 0;

  if_id_stage dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .imem_data (imem_data),
    .stall     (stall),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .valid_d   (valid_d),
    .jon_d     (jon_d),
    .addr_d    (addr_d),
`ifdef IF_ID_PERF_CNT_EN
    .perf_jump   (perf_jump),
    .perf_branch (perf_branch),
    .perf_bubble (perf_bubble),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and wait until just after the capturing edge.
  task automatic applyStimulus(input logic r, input logic [31:0] p,
                               input logic [31:0] d, input logic s);
    @(negedge clk);
    rst       = r;
    pc        = p;
    imem_data = d;
    stall     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  localparam logic [31:0] JUMP40   = {6'd40, 26'h000040};
  localparam logic [31:0] JUMP20   = {6'd40, 26'h000020};
  localparam logic [31:0] BEQ_W    = {6'd32, 26'h0000_123};
  localparam logic [31:0] BNE_W    = {6'd33, 26'h0000_055};
  localparam logic [31:0] HALT_W   = {6'b111111, 26'h0};

  initial begin
    // Reset
    applyStimulus(1'b1, 32'd7, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 32'd7, 32'hDEAD_BEEF, 1'b1);
    checkOutput("rst_instr", instr_d, 32'h0);
    checkOutput("rst_pc", pc_d, 32'd0);
    checkOutput("rst_valid", {31'd0, valid_d}, 32'd0);
    checkOutput("rst_jon", {30'd0, jon_d}, 32'd0);
    checkOutput("rst_addr", {6'd0, addr_d}, 32'd0);
    checkOutput("rst_halt", {31'd0, halted}, 32'd0);

    // Straight-line fetch
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, i, i + 1, 1'b0);
      checkOutput("seq_instr", instr_d, i + 1);
      checkOutput("seq_pc", pc_d, i);
      checkOutput("seq_valid", {31'd0, valid_d}, 32'd1);
      checkOutput("seq_jon", {30'd0, jon_d}, 32'd0);
    end

    // Jump: one-slot shadow
    applyStimulus(1'b0, 32'd5, JUMP40, 1'b0);
    checkOutput("j_jon", {30'd0, jon_d}, 32'd1);
    checkOutput("j_addr", {6'd0, addr_d}, 32'h40);
    checkOutput("j_valid", {31'd0, valid_d}, 32'd1);
    applyStimulus(1'b0, 32'd6, 32'h0000_0011, 1'b0);
    checkOutput("jsh_valid", {31'd0, valid_d}, 32'd0);
    checkOutput("jsh_instr", instr_d, 32'h0);
    checkOutput("jsh_jon", {30'd0, jon_d}, 32'd0);
    checkOutput("jsh_pc", pc_d, 32'd6);
    applyStimulus(1'b0, 32'd16, 32'h0000_0007, 1'b0);
    checkOutput("jt_valid", {31'd0, valid_d}, 32'd1);
    checkOutput("jt_instr", instr_d, 32'h7);
    checkOutput("jt_pc", pc_d, 32'd16);

    // Branch: two-slot shadow, a jump inside the shadow is ignored
    applyStimulus(1'b0, 32'd8, BEQ_W, 1'b0);
    checkOutput("b_jon", {30'd0, jon_d}, 32'd2);
    checkOutput("b_valid", {31'd0, valid_d}, 32'd1);
    applyStimulus(1'b0, 32'd9, JUMP20, 1'b0);
    checkOutput("bsh1_valid", {31'd0, valid_d}, 32'd0);
    checkOutput("bsh1_jon", {30'd0, jon_d}, 32'd0);
    applyStimulus(1'b0, 32'd10, 32'h0000_0008, 1'b0);
    checkOutput("bsh2_valid", {31'd0, valid_d}, 32'd0);
    checkOutput("bsh2_pc", pc_d, 32'd10);
    applyStimulus(1'b0, 32'd11, 32'h0000_0009, 1'b0);
    checkOutput("bpost_valid", {31'd0, valid_d}, 32'd1);
    checkOutput("bpost_instr", instr_d, 32'h9);

    // Stall in the middle of a branch shadow
    applyStimulus(1'b0, 32'd12, BNE_W, 1'b0);
    checkOutput("sb_jon", {30'd0, jon_d}, 32'd2);
    applyStimulus(1'b0, 32'd13, 32'h0000_0021, 1'b0);
    checkOutput("sb_sh1_valid", {31'd0, valid_d}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd14, 32'h0000_0022, 1'b1);
      checkOutput("stall_pc", pc_d, 32'd13);
      checkOutput("stall_valid", {31'd0, valid_d}, 32'd0);
      checkOutput("stall_instr", instr_d, 32'h0);
    end
    applyStimulus(1'b0, 32'd14, 32'h0000_0022, 1'b0);
    checkOutput("post_stall_valid", {31'd0, valid_d}, 32'd0);
    checkOutput("post_stall_pc", pc_d, 32'd14);
    applyStimulus(1'b0, 32'd15, 32'h0000_00AB, 1'b0);
    checkOutput("post_stall2_valid", {31'd0, valid_d}, 32'd1);
    checkOutput("post_stall2_instr", instr_d, 32'hAB);

    // Halt word in a jump shadow is squashed
    applyStimulus(1'b0, 32'd17, JUMP20, 1'b0);
    checkOutput("jh_jon", {30'd0, jon_d}, 32'd1);
    applyStimulus(1'b0, 32'd18, HALT_W, 1'b0);
    checkOutput("jh_valid", {31'd0, valid_d}, 32'd0);
    checkOutput("jh_halted", {31'd0, halted}, 32'd0);
    applyStimulus(1'b0, 32'd19, 32'h0000_0003, 1'b0);
    checkOutput("jh_next_valid", {31'd0, valid_d}, 32'd1);
    checkOutput("jh_next_halted", {31'd0, halted}, 32'd0);

    // Halt: stalled first, then accepted, then frozen
    applyStimulus(1'b0, 32'd20, HALT_W, 1'b1);
    checkOutput("hs_halted", {31'd0, halted}, 32'd0);
    checkOutput("hs_pc", pc_d, 32'd19);
    applyStimulus(1'b0, 32'd20, HALT_W, 1'b0);
    checkOutput("h_halted", {31'd0, halted}, 32'd1);
    checkOutput("h_pc", pc_d, 32'd20);
    checkOutput("h_valid", {31'd0, valid_d}, 32'd1);
    checkOutput("h_instr", instr_d, HALT_W);
    applyStimulus(1'b0, 32'd21, JUMP40, 1'b0);
    applyStimulus(1'b0, 32'd22, 32'h0000_0055, 1'b0);
    checkOutput("hf_pc", pc_d, 32'd20);
    checkOutput("hf_instr", instr_d, HALT_W);
    checkOutput("hf_jon", {30'd0, jon_d}, 32'd0);
    checkOutput("hf_halted", {31'd0, halted}, 32'd1);

    // Reset clears the halt
    applyStimulus(1'b1, 32'd22, 32'h0000_0055, 1'b0);
    checkOutput("r2_halted", {31'd0, halted}, 32'd0);
    checkOutput("r2_valid", {31'd0, valid_d}, 32'd0);
    checkOutput("r2_pc", pc_d, 32'd0);
    checkOutput("r2_instr", instr_d, 32'h0);

    // Reset mid-shadow drops the squash count
    applyStimulus(1'b0, 32'd30, BEQ_W, 1'b0);
    applyStimulus(1'b1, 32'd31, 32'h0000_0001, 1'b0);
    applyStimulus(1'b0, 32'd31, 32'h0000_0031, 1'b0);
    checkOutput("rsh_valid", {31'd0, valid_d}, 32'd1);
    checkOutput("rsh_instr", instr_d, 32'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
